// File: rtl/morra_cinese_fsmd.sv
// morra_cinese_fsmd: rock-paper-scissors referee (FSM + datapath), one round per clock.
// Revision: 1.0
`default_nettype none

module morra_cinese_fsmd #(
    parameter int MIN_MANCHE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] primo,
    input  logic [1:0] secondo,
    input  logic       inizia,
    output logic [1:0] manche,
    output logic [1:0] partita
);

    localparam logic [1:0] MOVE_NONE = 2'b00;
    localparam logic [1:0] SASSO     = 2'b01;
    localparam logic [1:0] CARTA     = 2'b10;
    localparam logic [1:0] FORBICE   = 2'b11;

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_P1   = 2'b01;
    localparam logic [1:0] RES_P2   = 2'b10;
    localparam logic [1:0] RES_TIE  = 2'b11;

    localparam logic [4:0] MIN_W = 5'(MIN_MANCHE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_END  = 2'd2
    } state_t;

    state_t     state;
    logic [4:0] max_manche;
    logic [4:0] rounds;
    logic [4:0] wins1;
    logic [4:0] wins2;
    logic [1:0] last_winner;
    logic [1:0] last_move;

    logic       p1_beats;
    logic [1:0] round_res;
    logic       repeat_viol;
    logic       round_valid;
    logic [4:0] next_rounds;
    logic [4:0] next_wins1;
    logic [4:0] next_wins2;
    logic [1:0] leader;
    logic       early_end;
    logic       last_round;
    logic [1:0] match_res;

    always_comb begin
        p1_beats = ((primo == SASSO)   && (secondo == FORBICE)) ||
                   ((primo == FORBICE) && (secondo == CARTA))   ||
                   ((primo == CARTA)   && (secondo == SASSO));

        if (primo == secondo)
            round_res = RES_TIE;
        else if (p1_beats)
            round_res = RES_P1;
        else
            round_res = RES_P2;

        // A previous winner may not reuse the move it won with; ties leave no record.
        repeat_viol = ((last_winner == RES_P1) && (primo   == last_move)) ||
                      ((last_winner == RES_P2) && (secondo == last_move));

        round_valid = (primo != MOVE_NONE) && (secondo != MOVE_NONE) && !repeat_viol;

        next_rounds = rounds + 5'd1;
        next_wins1  = wins1 + {4'd0, (round_res == RES_P1)};
        next_wins2  = wins2 + {4'd0, (round_res == RES_P2)};

        if (next_wins1 > next_wins2)
            leader = RES_P1;
        else if (next_wins2 > next_wins1)
            leader = RES_P2;
        else
            leader = RES_TIE;

        early_end  = (next_rounds >= MIN_W) &&
                     ((next_wins1 >= next_wins2 + 5'd2) || (next_wins2 >= next_wins1 + 5'd2));
        last_round = (next_rounds == max_manche);

        if (early_end || last_round)
            match_res = leader;
        else
            match_res = RES_NONE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            max_manche  <= 5'd0;
            rounds      <= 5'd0;
            wins1       <= 5'd0;
            wins2       <= 5'd0;
            last_winner <= RES_NONE;
            last_move   <= MOVE_NONE;
            manche      <= RES_NONE;
            partita     <= RES_NONE;
        end else begin
            manche  <= RES_NONE;
            partita <= RES_NONE;
            if (inizia) begin
                max_manche  <= {1'b0, primo, secondo} + MIN_W;
                rounds      <= 5'd0;
                wins1       <= 5'd0;
                wins2       <= 5'd0;
                last_winner <= RES_NONE;
                last_move   <= MOVE_NONE;
                state       <= S_PLAY;
            end else begin
                case (state)
                    S_PLAY: begin
                        if (round_valid) begin
                            manche  <= round_res;
                            partita <= match_res;
                            rounds  <= next_rounds;
                            wins1   <= next_wins1;
                            wins2   <= next_wins2;
                            if (round_res == RES_TIE) begin
                                last_winner <= RES_NONE;
                                last_move   <= MOVE_NONE;
                            end else begin
                                last_winner <= round_res;
                                last_move   <= (round_res == RES_P1) ? primo : secondo;
                            end
                            if (match_res != RES_NONE)
                                state <= S_END;
                        end
                    end
                    S_END:   state <= S_END;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_morra_cinese_fsmd.sv
// tb_morra_cinese_fsmd: scoreboard bench for the morra cinese referee.
// Revision: 1.0
`default_nettype none

module tb_morra_cinese_fsmd;

    localparam logic [1:0] NO = 2'b00;
    localparam logic [1:0] SA = 2'b01;
    localparam logic [1:0] CA = 2'b10;
    localparam logic [1:0] FO = 2'b11;
    localparam logic [1:0] P1 = 2'b01;
    localparam logic [1:0] P2 = 2'b10;
    localparam logic [1:0] TI = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] primo = 2'b00;
    logic [1:0] secondo = 2'b00;
    logic       inizia = 1'b0;
    logic [1:0] manche;
    logic [1:0] partita;

    typedef struct {
        logic [3:0] exp;
        string      name;
    } sb_item_t;

    sb_item_t sb[$];
    int checks = 0;
    int errors = 0;

    morra_cinese_fsmd #(.MIN_MANCHE(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .primo   (primo),
        .secondo (secondo),
        .inizia  (inizia),
        .manche  (manche),
        .partita (partita)
    );

    always #5 clk = ~clk;

    // Monitor: the DUT presents a registered result after every edge.
    initial begin
        sb_item_t item;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                item = sb.pop_front();
                checks++;
                if ({manche, partita} !== item.exp) begin
                    errors++;
                    $display("FAIL %s: manche/partita got %b/%b expected %b/%b",
                             item.name, manche, partita, item.exp[3:2], item.exp[1:0]);
                end
            end
        end
    end

    task automatic step(input logic rn, input logic ini, input logic [1:0] p,
                        input logic [1:0] s, input logic [1:0] em, input logic [1:0] ep,
                        input string nm);
        sb_item_t it;
        @(negedge clk);
        rst_n   = rn;
        inizia  = ini;
        primo   = p;
        secondo = s;
        it.exp  = {em, ep};
        it.name = nm;
        sb.push_back(it);
    endtask

    initial begin
        step(0, 0, NO, NO, NO, NO, "reset");
        step(0, 0, SA, FO, NO, NO, "reset_hold");
        step(1, 0, SA, FO, NO, NO, "idle_moves");

        // max = 2 + 4 = 6
        step(1, 1, NO, CA, NO, NO, "cfg_max6");
        step(1, 0, SA, CA, P2, NO, "r1_p2_carta");
        step(1, 0, FO, CA, NO, NO, "p2_repeat_carta");
        step(1, 0, SA, FO, P1, NO, "r2_p1");
        step(1, 0, FO, FO, TI, NO, "r3_tie");
        step(1, 0, CA, FO, P2, NO, "r4_p2");
        step(1, 0, SA, FO, NO, NO, "p2_repeat_forbice");
        step(1, 0, CA, SA, P1, NO, "r5_p1");
        step(1, 0, SA, SA, TI, TI, "r6_draw_at_max");
        step(1, 0, SA, FO, NO, NO, "end_moves");

        // max = 4; restart after two rounds must clear counts and record
        step(1, 1, NO, NO, NO, NO, "cfg_max4");
        step(1, 0, SA, FO, P1, NO, "pre_r1");
        step(1, 0, CA, SA, P1, NO, "pre_r2");
        step(1, 1, NO, NO, NO, NO, "restart");
        step(1, 0, SA, FO, P1, NO, "ew_r1");
        step(1, 0, CA, SA, P1, NO, "ew_r2");
        step(1, 0, SA, FO, P1, NO, "ew_r3_3to0");
        step(1, 0, CA, SA, P1, P1, "ew_r4_early_win");
        step(1, 0, CA, SA, NO, NO, "end_moves2");

        // max = 1 + 4 = 5, match decided by leader at max
        step(1, 1, NO, SA, NO, NO, "cfg_max5");
        step(1, 0, SA, FO, P1, NO, "ld_r1");
        step(1, 0, FO, SA, P2, NO, "ld_r2");
        step(1, 0, NO, CA, NO, NO, "invalid_p1_none");
        step(1, 0, CA, CA, TI, NO, "ld_r3_tie");
        step(1, 0, SA, FO, P1, NO, "ld_r4");
        step(1, 0, SA, CA, NO, NO, "p1_repeat_sasso");
        step(1, 0, CA, CA, TI, P1, "ld_r5_leader_at_max");

        step(0, 1, CA, NO, NO, NO, "rst_with_inizia");
        step(1, 0, SA, FO, NO, NO, "idle_after_rst");

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: pending %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/morra_cinese_fsmd.md
Name: morra_cinese_fsmd

Overview:
- Two-player rock-paper-scissors ("morra cinese") referee, built as an FSM plus datapath.
- Each cycle it samples both players' moves, judges the round (manche), tracks score and round count, and declares the match (partita) result.
- It is a standalone game controller, driven by a single clock with one round per cycle.

Parameters:
- MIN_MANCHE, 4, minimum valid rounds before a match can end early; also the offset added to the configured maximum.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  synchronous active-low reset.
- primo  input  2  player 1 move: 00 none/invalid, 01 sasso, 10 carta, 11 forbice; maximum-round config high bits when inizia=1.
- secondo  input  2  player 2 move, same encoding; maximum-round config low bits when inizia=1.
- inizia  input  1  start/restart a match.
- manche  output  2  registered round result: 00 invalid or no round, 01 player 1 wins, 10 player 2 wins, 11 tie.
- partita  output  2  registered match result: 00 in progress or idle, 01 player 1 wins, 10 player 2 wins, 11 draw.

Behaviour:
- Outputs are registered. The values after rising edge N reflect the inputs sampled at edge N.
- Reset (rst_n=0 at an edge):
  - state=IDLE; manche=00, partita=00.
  - Counters cleared; last-winner memory cleared.
  - Reset overrides inizia.
- inizia=1, from any state (restart mid-match allowed):
  - max_manche = {primo,secondo} + MIN_MANCHE, a 5-bit value in the range 4..19.
  - Clear round count, both win counts and the last-winner record; go to PLAY.
  - manche=00, partita=00 that cycle.
- IDLE: moves ignored; outputs 00/00 until inizia.
- PLAY, inizia=0: a round is invalid if either move is 00.
- Repeat rule: a round is also invalid if the previous valid round had a winner and that winner repeats the move it won with.
  - Ties set no restriction.
  - Invalid rounds clear no restriction.
- Invalid round: manche=00, partita=00; no counters change.
- Valid round:
  - Winner rules: sasso beats forbice, forbice beats carta, carta beats sasso; equal moves tie.
  - manche=01, 10 or 11 accordingly.
  - Round count increments; the winner's win count increments.
  - Record the winner and its move; a tie clears the record.
- Match end, evaluated with the updated counts in the same cycle as the round:
  - (a) round count >= MIN_MANCHE and |wins1 - wins2| >= 2: partita goes to the leader.
  - (b) otherwise, round count == max_manche: partita = leader, or 11 if wins are equal.
  - On end: partita is set for that one cycle together with that round's manche, then state goes to END.
- END: moves ignored; manche=00, partita=00 until inizia.
- Win and round counters are 5 bits; they saturate-free because they are bounded by max_manche <= 19.

Test Plan:
- Reset then configure and play:
  - rst_n=0 -> 00/00.
  - inizia=1, primo=00, secondo=10 -> max=6, 00/00.
  - Sasso vs carta -> manche=10, partita=00.
- Repeat rule: continuing from the previous scenario, forbice vs carta -> manche=00 (player 2 repeated winning carta), round count unchanged.
- Full 6-round sequence with max=6:
  - Sasso/forbice -> 01.
  - Forbice/forbice -> 11.
  - Carta/forbice -> 10.
  - Sasso/forbice -> 00 (player 2 repeat).
  - Carta/sasso -> 01.
  - Next tie -> manche=11, partita=11 (round 6, wins 2:2).
- Early win: max=4 config 00/00; player 1 wins rounds 1-4 with alternating moves -> round 4: manche=01, partita=01; earlier rounds partita=00 even at 3:0.
- Invalid input: primo=00 in PLAY -> manche=00, no count change.
- Edge cases:
  - inizia mid-match restarts the match with counts cleared.
  - Moves in END or IDLE -> 00/00.
  - rst_n=0 concurrent with inizia=1 -> IDLE.
